// File: rtl/seqshifter_pkg.sv
// Shared definitions for the iterative shifter: FSM state type and funnel width.
// Optional rotate support is selected with the ZBB_ROTATE_EN macro (see seqshift_funnel).
package cvw;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } seqshift_state_t;

    localparam int unsigned XLEN_DEFAULT = 64;
    localparam int unsigned FUNNEL_W     = 2 * XLEN_DEFAULT - 1;

    function automatic int unsigned funnel_width(input int unsigned xlen);
        return 2 * xlen - 1;
    endfunction

endpackage

// File: rtl/seqshifter_if.sv
// Request/response bundle between the execute stage (master) and the shifter (slave).
interface seqshifter_if #(
    parameter int XLEN     = 64,
    parameter int LOG_XLEN = $clog2(XLEN)
);
    logic                ReqValid;
    logic                ReqReady;
    logic [XLEN-1:0]     A;
    logic [LOG_XLEN-1:0] Amt;
    logic                Right;
    logic                Rotate;
    logic                W64;
    logic                SubArith;
    logic                Flush;
    logic                RespValid;
    logic                RespReady;
    logic [XLEN-1:0]     Y;

    modport master (
        output ReqValid, A, Amt, Right, Rotate, W64, SubArith, Flush, RespReady,
        input  ReqReady, RespValid, Y
    );

    modport slave (
        input  ReqValid, A, Amt, Right, Rotate, W64, SubArith, Flush, RespReady,
        output ReqReady, RespValid, Y
    );
endinterface

// File: rtl/seqshift_funnel.sv
// Combinational operand former: word extension, funnel construction and offset selection.
// ZBB_ROTATE_EN adds the rotate funnel; without it Rotate is ignored.
module seqshift_funnel import cvw::*; #(
    parameter int XLEN     = 64,
    parameter int LOG_XLEN = $clog2(XLEN),
    parameter int ZW       = int'(funnel_width(XLEN))
) (
    input  logic [XLEN-1:0]     A,
    input  logic [LOG_XLEN-1:0] Amt,
    input  logic                Right,
    input  logic                Rotate,
    input  logic                W64,
    input  logic                SubArith,
    output logic [ZW-1:0]       Z,
    output logic [LOG_XLEN-1:0] Offset,
    output logic                W
);
    logic [XLEN-1:0]     src;
    logic [LOG_XLEN-1:0] amt_eff;
    logic                sign;
`ifdef ZBB_ROTATE_EN
    logic [XLEN-1:0]     rot_a;
`else
    logic                unused_rotate;
    assign unused_rotate = Rotate;
`endif

    always_comb begin
        W       = W64 & (XLEN == 64);
        amt_eff = Amt;
        src     = A;
        if (W) begin
            amt_eff = LOG_XLEN'(Amt[4:0]);
            src     = SubArith ? XLEN'($signed(A[31:0])) : XLEN'(A[31:0]);
        end
        sign = src[XLEN-1] & SubArith;

        // Left shifts walk the funnel right by ~Amt, i.e. XLEN-1-Amt.
        if (Right) begin
            Z      = {{(XLEN-1){sign}}, src};
            Offset = amt_eff;
        end else begin
            Z      = {src, {(XLEN-1){1'b0}}};
            Offset = ~amt_eff;
        end

`ifdef ZBB_ROTATE_EN
        rot_a = W ? XLEN'({A[31:0], A[31:0]}) : A;
        if (Rotate) begin
            if (Right) Z = {rot_a[XLEN-2:0], rot_a};
            else       Z = {rot_a, rot_a[XLEN-1:1]};
        end
`endif
    end
endmodule

// File: rtl/seqshifter.sv
// Iterative shift/rotate unit: resolves one offset bit per cycle, LOG_XLEN cycles per result.
// Rotate support depends on ZBB_ROTATE_EN (handled in seqshift_funnel).
module seqshifter import cvw::*; #(
    parameter int XLEN     = 64,
    parameter int LOG_XLEN = $clog2(XLEN)
) (
    input  logic         clk,
    input  logic         reset_n,
    seqshifter_if.slave  bus
);
    localparam int ZW = int'(funnel_width(XLEN));

    seqshift_state_t     state, state_n;
    logic [ZW-1:0]       z, z_cap, z_step;
    logic [LOG_XLEN-1:0] offset, off_cap, cnt;
    logic                w_q, w_cap;
    logic [XLEN-1:0]     y, y_next;
    logic                accept, last;

    seqshift_funnel #(
        .XLEN     (XLEN),
        .LOG_XLEN (LOG_XLEN),
        .ZW       (ZW)
    ) u_funnel (
        .A        (bus.A),
        .Amt      (bus.Amt),
        .Right    (bus.Right),
        .Rotate   (bus.Rotate),
        .W64      (bus.W64),
        .SubArith (bus.SubArith),
        .Z        (z_cap),
        .Offset   (off_cap),
        .W        (w_cap)
    );

    always_comb begin
        state_n       = state;
        accept        = 1'b0;
        bus.ReqReady  = 1'b0;
        bus.RespValid = 1'b0;
        last          = (cnt == LOG_XLEN'(LOG_XLEN - 1));

        case (state)
            IDLE: begin
                bus.ReqReady = 1'b1;
                if (bus.ReqValid) begin
                    accept  = 1'b1;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (bus.Flush)  state_n = IDLE;
                else if (last)  state_n = DONE;
            end
            DONE: begin
                bus.RespValid = 1'b1;
                bus.ReqReady  = bus.RespReady;
                if (bus.Flush) begin
                    state_n = IDLE;
                end else if (bus.RespReady) begin
                    if (bus.ReqValid) begin
                        accept  = 1'b1;
                        state_n = BUSY;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        z_step = offset[cnt] ? (z >> (1 << cnt)) : z;
        y_next = w_q ? XLEN'($signed(z_step[31:0])) : z_step[XLEN-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            z      <= '0;
            offset <= '0;
            cnt    <= '0;
            w_q    <= 1'b0;
            y      <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                z      <= z_cap;
                offset <= off_cap;
                w_q    <= w_cap;
                cnt    <= '0;
            end else if (state == BUSY && !bus.Flush) begin
                z   <= z_step;
                cnt <= cnt + 1'b1;
                if (last) y <= y_next;
            end
        end
    end

    assign bus.Y = y;
endmodule

// File: tb/tb_seqshifter.sv
// Randomized and directed check of seqshifter (XLEN=64) against a behavioural reference model.
module tb_seqshifter;
    localparam int XLEN = 64;
    localparam int LW   = 6;

`ifdef ZBB_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    seqshifter_if #(.XLEN(XLEN)) bus();
    seqshifter #(.XLEN(XLEN)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    // Model state: one operation in flight, result due LW edges after acceptance.
    bit          inflight = 1'b0;
    longint      cyc = 0;
    longint      acc = 0;
    logic [63:0] exp_y = '0;
    bit          check_en = 1'b0;

    function automatic logic [63:0] ref_y(input logic [63:0] a, input logic [5:0] amt,
                                          input bit right, input bit rot, input bit w, input bit sa);
        int unsigned s;
        logic [31:0] lo, r32;
        logic [63:0] r;
        s   = w ? int'(amt[4:0]) : int'(amt);
        lo  = a[31:0];
        r32 = '0;
        r   = '0;
        if (rot && ROT_EN) begin
            if (w) r32 = right ? ((lo >> s) | (lo << (32 - s))) : ((lo << s) | (lo >> (32 - s)));
            else   r   = right ? ((a >> s) | (a << (64 - s)))   : ((a << s) | (a >> (64 - s)));
        end else if (right) begin
            if (w) begin
                if (sa) r32 = $signed(lo) >>> s;
                else    r32 = lo >> s;
            end else begin
                if (sa) r = $signed(a) >>> s;
                else    r = a >> s;
            end
        end else begin
            if (w) r32 = lo << s;
            else   r   = a << s;
        end
        if (w) r = {{32{r32[31]}}, r32};
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge reset_n) inflight = 1'b0;

    always @(posedge clk) begin
        if (reset_n) begin
            automatic bit rv = inflight && (cyc - acc >= LW);
            automatic bit rr = !inflight || (rv && bus.RespReady);
            cyc++;
            if (bus.Flush && inflight) begin
                inflight = 1'b0;
            end else begin
                if (rv && bus.RespReady) inflight = 1'b0;
                if (bus.ReqValid && rr) begin
                    inflight = 1'b1;
                    acc      = cyc;
                    exp_y    = ref_y(bus.A, bus.Amt, bus.Right, bus.Rotate, bus.W64, bus.SubArith);
                end
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (check_en) begin
            automatic bit rv = inflight && (cyc - acc >= LW);
            automatic bit rr = !inflight || (rv && bus.RespReady);
            check("RespValid", 64'(bus.RespValid), 64'(rv));
            check("ReqReady", 64'(bus.ReqReady), 64'(rr));
            if (rv) check("Y", bus.Y, exp_y);
        end
    end

    task automatic set_op(input logic [63:0] a, input logic [5:0] amt,
                          input bit right, input bit rot, input bit w, input bit sa);
        bus.A = a; bus.Amt = amt; bus.Right = right; bus.Rotate = rot; bus.W64 = w; bus.SubArith = sa;
    endtask

    task automatic wait_resp(input string name, output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            #2;
            if (bus.RespValid) return;
        end
        check({name, "_timeout"}, 64'(bus.RespValid), 64'd1);
    endtask

    task automatic do_op(input string name, input logic [63:0] a, input logic [5:0] amt,
                         input bit right, input bit rot, input bit w, input bit sa,
                         input logic [63:0] lit);
        int lat;
        @(negedge clk);
        set_op(a, amt, right, rot, w, sa);
        bus.ReqValid = 1'b1;
        bus.RespReady = 1'b1;
        @(posedge clk);
        #1 bus.ReqValid = 1'b0;
        wait_resp(name, lat);
        check({name, "_lat"}, 64'(lat), 64'(LW));
        check({name, "_y"}, bus.Y, lit);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        bus.ReqValid = 0; bus.RespReady = 0; bus.Flush = 0;
        set_op('0, '0, 0, 0, 0, 0);
        check_en = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("rst_Y", bus.Y, 64'h0);
        check("rst_RespValid", 64'(bus.RespValid), 64'd0);
        check("rst_ReqReady", 64'(bus.ReqReady), 64'd1);
        reset_n = 1'b1;

        check("model_sraw", ref_y(64'h0000_0000_8000_0000, 6'd36, 1, 0, 1, 1), 64'hFFFF_FFFF_F800_0000);
        check("model_sllw", ref_y(64'h0000_0000_4000_0001, 6'd1, 0, 0, 1, 0), 64'hFFFF_FFFF_8000_0002);

        do_op("sll63", 64'h1, 6'd63, 0, 0, 0, 0, 64'h8000_0000_0000_0000);
        do_op("sra4", 64'h8000_0000_0000_0000, 6'd4, 1, 0, 0, 1, 64'hF800_0000_0000_0000);
        do_op("srl4", 64'h8000_0000_0000_0000, 6'd4, 1, 0, 0, 0, 64'h0800_0000_0000_0000);
        do_op("sraw", 64'h0000_0000_8000_0000, 6'd36, 1, 0, 1, 1, 64'hFFFF_FFFF_F800_0000);
        do_op("sllw", 64'h0000_0000_4000_0001, 6'd1, 0, 0, 1, 0, 64'hFFFF_FFFF_8000_0002);
        do_op("ror1", 64'h1, 6'd1, 1, 1, 0, 0, ROT_EN ? 64'h8000_0000_0000_0000 : 64'h0);
        do_op("sll0", 64'h0123_4567_89AB_CDEF, 6'd0, 0, 0, 0, 0, 64'h0123_4567_89AB_CDEF);
        do_op("srl0", 64'h0123_4567_89AB_CDEF, 6'd0, 1, 0, 0, 1, 64'h0123_4567_89AB_CDEF);

        // Backpressure then same-cycle consume/accept.
        @(negedge clk);
        set_op(64'h3, 6'd2, 0, 0, 0, 0);
        bus.ReqValid = 1'b1;
        bus.RespReady = 1'b0;
        @(posedge clk);
        #1 bus.ReqValid = 1'b0;
        wait_resp("bp", lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            check("bp_hold_y", bus.Y, 64'hC);
            check("bp_hold_rdy", 64'(bus.ReqReady), 64'd0);
        end
        @(negedge clk);
        set_op(64'h100, 6'd8, 1, 0, 0, 0);
        bus.ReqValid = 1'b1;
        bus.RespReady = 1'b1;
        @(posedge clk);
        #1;
        bus.ReqValid = 1'b0;
        check("bp_b2b_valid", 64'(bus.RespValid), 64'd0);
        check("bp_b2b_rdy", 64'(bus.ReqReady), 64'd0);
        wait_resp("bp2", lat);
        check("bp2_lat", 64'(lat), 64'(LW));
        check("bp2_y", bus.Y, 64'h1);
        @(posedge clk);

        // Flush on the third BUSY cycle.
        @(negedge clk);
        set_op(64'hFF, 6'd4, 0, 0, 0, 0);
        bus.ReqValid = 1'b1;
        @(posedge clk);
        #1 bus.ReqValid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.Flush = 1'b1;
        @(posedge clk);
        #1;
        bus.Flush = 1'b0;
        check("flush_valid", 64'(bus.RespValid), 64'd0);
        check("flush_rdy", 64'(bus.ReqReady), 64'd1);
        repeat (8) @(posedge clk);

        // Asynchronous reset in the middle of BUSY.
        @(negedge clk);
        set_op(64'h5, 6'd1, 0, 0, 0, 0);
        bus.ReqValid = 1'b1;
        @(posedge clk);
        #1 bus.ReqValid = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(bus.RespValid), 64'd0);
        check("arst_y", bus.Y, 64'h0);
        check("arst_rdy", 64'(bus.ReqReady), 64'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic with occasional flushes and boundary amounts.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            bus.ReqValid  = ($urandom_range(0, 2) != 0);
            bus.RespReady = ($urandom_range(0, 3) != 0);
            bus.Flush     = ($urandom_range(0, 39) == 0);
            bus.A         = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0:       bus.Amt = 6'd0;
                1:       bus.Amt = 6'd63;
                default: bus.Amt = 6'($urandom);
            endcase
            bus.Right    = 1'($urandom);
            bus.Rotate   = ($urandom_range(0, 3) == 0);
            bus.W64      = 1'($urandom);
            bus.SubArith = 1'($urandom);
        end
        @(negedge clk);
        bus.ReqValid = 1'b0; bus.Flush = 1'b0; bus.RespReady = 1'b1;
        repeat (10) @(negedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seqshifter.md
# seqshifter

Iterative multi-cycle shift/rotate unit for area-constrained RV32/RV64 IEU configurations. It responds to shift requests issued by the execute stage over a valid/ready handshake. It forms the same funnel operand as the single-cycle shifter, then resolves one bit of the shift offset per cycle, so a result takes LOG_XLEN cycles. The returned result is sign-extended for W-type operations.

## Interface
Parameters:
- XLEN, 64: datapath width; 32 or 64.
- LOG_XLEN, $clog2(XLEN): width of the shift amount.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- ReqValid  in  1  request present.
- ReqReady  out  1  unit can accept a request.
- A  in  XLEN  shift source.
- Amt  in  LOG_XLEN  shift amount.
- Right, Rotate, W64, SubArith  in  1 each  operation qualifiers; W64 is ignored when XLEN=32.
- Flush  in  1  kill the in-flight operation.
- RespValid  out  1  result available.
- RespReady  in  1  consumer accepts the result.
- Y  out  XLEN  shifted result.

## Operation
State machine:
- States are IDLE, BUSY and DONE. Reset state is IDLE.
- IDLE → BUSY on ReqValid & ReqReady.
- BUSY → DONE after LOG_XLEN steps.
- DONE → IDLE on RespReady & !ReqValid.
- DONE → BUSY on RespReady & ReqValid: the new request is accepted in the same cycle the response is consumed.

Handshake signals:
- ReqReady = (IDLE) | (DONE & RespReady).
- RespValid = DONE.

Operand capture (on acceptance):
- Sign = A[XLEN-1] & SubArith.
- For RV64 with W64=1, the source is A[31:0] extended to 64 bits: sign-extended if SubArith, zero-extended otherwise. The shift amount is {0, Amt[4:0]}.
- Funnel register Z, width 2·XLEN−1:
  - left: {A, zeros}
  - right: {XLEN−1 copies of Sign, A}
- Offset register = Right ? Amt : ~Amt (after truncation).
- A step counter is cleared to 0.

BUSY step k (k = 0..LOG_XLEN−1):
- If Offset[k], Z ← Z >> 2^k; otherwise Z holds.
- The counter increments.
- No early exit: latency is fixed regardless of Amt.

Result:
- Y = W64 ? sign-extend(Z[31:0]) : Z[XLEN-1:0].
- Y is registered and held stable throughout DONE.

Boundary cases:
- Amt=0 returns A unchanged (left: Offset = all ones; right: Offset = 0).
- Flush in BUSY or DONE → IDLE at the next edge. No response is produced, and a request presented in that cycle is not accepted.
- Flush in IDLE has no effect.
- reset_n asserted at any point → IDLE immediately, with RespValid=0 and Y=0. Deassertion is synchronized externally.

## Timing
- Reset values: ReqReady=1, RespValid=0, Y=0.
- Request accepted at edge t → RespValid high after edge t+LOG_XLEN. That is 6 cycles for XLEN=64 and 5 cycles for XLEN=32.
- Back-to-back throughput: one result per LOG_XLEN cycles when RespReady is held high.
- Outputs are registered. There is no combinational path from ReqValid/A to Y.
- ReqReady depends combinationally on RespReady in DONE only.

## Configuration
- ZBB_ROTATE_EN defined: Rotate=1 selects the rotate funnel.
  - RotA = W64 ? {A[31:0], A[31:0]} : A.
  - Left rotate: Z = {RotA, RotA[XLEN-1:1]}.
  - Right rotate: Z = {RotA[XLEN-2:0], RotA}.
- ZBB_ROTATE_EN undefined: the Rotate input is ignored and treated as 0. The rotate funnel and RotA logic are not synthesized.

## Structure
- Shared package cvw holds:
  - the seqshift_state_t enum (IDLE, BUSY, DONE);
  - a constant for the funnel width, 2·XLEN−1.
- One combinational sub-module, seqshift_funnel, contains the operand-forming logic: extension mux, rotate mux, funnel mux and Offset selection.
- The seqshifter top holds the FSM, counter, Z/Offset registers and result register.

## Test plan
All scenarios use XLEN=64.
- SLL, A=0x1, Amt=63, RespReady=1 → RespValid exactly 6 cycles after acceptance, Y=0x8000_0000_0000_0000.
- SRA, A=0x8000_0000_0000_0000, Amt=4, SubArith=1 → Y=0xF800_0000_0000_0000. Same operation with SubArith=0 → Y=0x0800_0000_0000_0000.
- SRAW, W64=1, A=0x0000_0000_8000_0000, Amt=36, SubArith=1 → amount truncated to 4, Y=0xFFFF_FFFF_F800_0000.
- ROR, Rotate=1, Right=1, A=0x1, Amt=1 → with ZBB_ROTATE_EN, Y=0x8000_0000_0000_0000. Without the macro, Y=0x0.
- Backpressure: hold RespReady=0 for 10 cycles in DONE → Y stable and ReqReady=0 throughout. Then raise RespReady with ReqValid=1 → response consumed and new request accepted in the same cycle.
- Flush asserted on the third BUSY cycle → IDLE next edge with no RespValid. Separately, reset_n low mid-BUSY → RespValid=0, Y=0 and ReqReady=1 immediately.
